mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/mole_scheduler_pkg.sv | 21 ++
 rtl/mole_scheduler_if.sv | 31 +++
 rtl/mole_timer.sv | 32 +++
 rtl/mole_scheduler.sv | 161 ++++++++++++++++
 tb/tb_mole_scheduler.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mole_scheduler_pkg.sv
// Shared definitions for the whack-a-mole scheduler.
//   NUM_HOLES : number of holes on the board
//   HIT_NONE  : hammer position code meaning "no hit this cycle"
//   state_t   : game state encoding (IDLE / RUN)
//   cand_hole : folds a 4-bit random value onto a hole index 0..8
package mole_scheduler_pkg;

  localparam int         NUM_HOLES = 9;
  localparam logic [3:0] HIT_NONE  = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Values 9..15 fold down to 0..6 so every random value names a hole.
  function automatic logic [3:0] cand_hole(input logic [3:0] r);
    return (r < 4'd9) ? r : (r - 4'd9);
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Game bus between the board controller and the mole scheduler.
//   en          : game running (master -> slave)
//   hit_pos     : one-cycle hammer position, 0..8 hole, 15 none
//   rnd         : free-running random value
//   map         : registered mole occupancy, bit i = hole i
//   active_cnt  : registered popcount of map
//   spawn_pulse : a mole was placed
//   hit_pulse   : an occupied hole was hit
//   whiff_pulse : an empty hole was hit
//   miss_pulse  : one or more moles expired
interface mole_scheduler_if;
  logic       en;
  logic [3:0] hit_pos;
  logic [8:0] rnd;
  logic [8:0] map;
  logic [3:0] active_cnt;
  logic       spawn_pulse;
  logic       hit_pulse;
  logic       whiff_pulse;
  logic       miss_pulse;

  modport master (
    output en, hit_pos, rnd,
    input  map, active_cnt, spawn_pulse, hit_pulse, whiff_pulse, miss_pulse
  );

  modport slave (
    input  en, hit_pos, rnd,
    output map, active_cnt, spawn_pulse, hit_pulse, whiff_pulse, miss_pulse
  );
endinterface

// File: rtl/mole_timer.sv
// Lifetime counter for one hole.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : a mole is placed in this hole; restart count at 0
//   i_clear   : hole emptied or game stopped; hold count at 0
//   i_run     : hole occupied during RUN; advance count
//   o_expire  : mole has been up MOLE_LIFE cycles; cleared on the next edge
module mole_timer #(
  parameter int unsigned MOLE_LIFE = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  logic [31:0] r_cnt;

  // The count never passes MOLE_LIFE-1: expiry clears the hole, which
  // asserts i_clear on the same edge, so 32 bits cannot overflow.
  always_ff @(posedge clk) begin
    if (rst || i_clear || i_load) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_expire = i_run && (r_cnt == (MOLE_LIFE - 32'd1));

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: periodically places moles in free holes, times
// them out, and scores hammer hits against the registered occupancy map.
//   clk, rst : clock, synchronous active-high reset (overrides en)
//   bus      : mole_scheduler_if.slave (en, hit_pos, rnd in; map,
//              active_cnt and the four event pulses out, all registered)
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int unsigned SPAWN_PERIOD = 50_000_000,
  parameter int unsigned MOLE_LIFE    = 100_000_000,
  parameter int unsigned MAX_ACTIVE   = 3
) (
  input  logic             clk,
  input  logic             rst,
  mole_scheduler_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_active;

  logic [8:0]  r_map;
  logic [3:0]  r_active_cnt;
  logic [31:0] r_spawn_cnt;
  logic        r_spawn_pulse;
  logic        r_hit_pulse;
  logic        r_whiff_pulse;
  logic        r_miss_pulse;

  logic        w_wrap;
  logic        w_hit_valid;
  logic [8:0]  w_hit_mask;
  logic        w_hit_occ;
  logic        w_whiff;
  logic [8:0]  w_expire;
  logic [8:0]  w_miss_mask;
  logic [8:0]  w_clr;
  logic [3:0]  w_cand;
  logic [4:0]  w_sum;
  logic [3:0]  w_idx;
  logic        w_found;
  logic [8:0]  w_scan_mask;
  logic        w_do_spawn;
  logic [8:0]  w_spawn_mask;
  logic [8:0]  w_map_nxt;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) begin
      s = s + {3'd0, v[i]};
    end
    return s;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (bus.en) begin
      w_state_nxt = ST_RUN;
    end
  end

  // Output decode: game logic acts only while RUN and en is still high;
  // dropping en in RUN makes the next edge a silent clear.
  always_comb begin
    w_active = (r_state == ST_RUN) && bus.en;
  end

  assign w_wrap = (r_spawn_cnt == (SPAWN_PERIOD - 32'd1));

  // Hammer decode; positions 9..14 fall outside the board like HIT_NONE.
  always_comb begin
    w_hit_valid = (bus.hit_pos < 4'(NUM_HOLES));
    w_hit_mask  = w_hit_valid ? (9'd1 << bus.hit_pos) : 9'd0;
    w_hit_occ   = |(w_hit_mask & r_map);
    w_whiff     = w_hit_valid && !w_hit_occ;
    // A hit on an expiring hole scores as a hit, not a miss.
    w_miss_mask = w_expire & ~w_hit_mask;
    w_clr       = (w_hit_mask & r_map) | w_expire;
  end

  // Cyclic free-hole scan from the candidate over the registered map, so a
  // hole emptied this cycle is not refilled until the next attempt.
  always_comb begin
    w_cand      = cand_hole(bus.rnd[3:0]);
    w_found     = 1'b0;
    w_scan_mask = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_HOLES; k++) begin
      w_sum = {1'b0, w_cand} + 5'(k);
      if (w_sum >= 5'(NUM_HOLES)) begin
        w_sum = w_sum - 5'(NUM_HOLES);
      end
      w_idx = w_sum[3:0];
      if (!w_found && (((r_map >> w_idx) & 9'd1) == 9'd0)) begin
        w_found     = 1'b1;
        w_scan_mask = 9'd1 << w_idx;
      end
    end
  end

  always_comb begin
    w_do_spawn   = w_active && w_wrap && w_found &&
                   (r_active_cnt != 4'(MAX_ACTIVE)) && (r_map != 9'h1FF);
    w_spawn_mask = w_do_spawn ? w_scan_mask : 9'd0;
    w_map_nxt    = w_active ? ((r_map & ~w_clr) | w_spawn_mask) : 9'd0;
  end

  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_timer
    mole_timer #(
      .MOLE_LIFE (MOLE_LIFE)
    ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_spawn_mask[gi]),
      .i_clear  (!w_active || w_clr[gi]),
      .i_run    (w_active && r_map[gi]),
      .o_expire (w_expire[gi])
    );
  end

  // Registered map, count, spawn timer and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_map         <= '0;
      r_active_cnt  <= '0;
      r_spawn_cnt   <= '0;
      r_spawn_pulse <= 1'b0;
      r_hit_pulse   <= 1'b0;
      r_whiff_pulse <= 1'b0;
      r_miss_pulse  <= 1'b0;
    end else begin
      r_map         <= w_map_nxt;
      r_active_cnt  <= popcount9(w_map_nxt);
      r_spawn_cnt   <= (!w_active || w_wrap) ? 32'd0 : (r_spawn_cnt + 32'd1);
      r_spawn_pulse <= w_do_spawn;
      r_hit_pulse   <= w_active && w_hit_occ;
      r_whiff_pulse <= w_active && w_whiff;
      r_miss_pulse  <= w_active && (|w_miss_mask);
    end
  end

  assign bus.map         = r_map;
  assign bus.active_cnt  = r_active_cnt;
  assign bus.spawn_pulse = r_spawn_pulse;
  assign bus.hit_pulse   = r_hit_pulse;
  assign bus.whiff_pulse = r_whiff_pulse;
  assign bus.miss_pulse  = r_miss_pulse;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with SPAWN_PERIOD=4, MOLE_LIFE=10,
// MAX_ACTIVE=2. Each table row gives the inputs applied before an edge and
// the outputs expected just after it; pul = {spawn, hit, whiff, miss}.
module tb_mole_scheduler;
  import mole_scheduler_pkg::*;

  logic clk;
  logic rst;
  mole_scheduler_if bus ();

  mole_scheduler #(
    .SPAWN_PERIOD (4),
    .MOLE_LIFE    (10),
    .MAX_ACTIVE   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] hit;
    logic [8:0] rnd;
    logic [8:0] map;
    logic [3:0] cnt;
    logic [3:0] pul;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] h,
                              input logic [8:0] rn, input logic [8:0] m,
                              input logic [3:0] c, input logic [3:0] p);
    vec_t v;
    v.rst = r; v.en = e; v.hit = h; v.rnd = rn;
    v.map = m; v.cnt = c; v.pul = p;
    return v;
  endfunction

  function automatic logic [3:0] pulses();
    return {bus.spawn_pulse, bus.hit_pulse, bus.whiff_pulse, bus.miss_pulse};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] m,
                       input logic [3:0] c, input logic [3:0] p);
    checks++;
    if (bus.map !== m || bus.active_cnt !== c || pulses() !== p) begin
      failures++;
      $display("FAIL %s got map=%h cnt=%0d pul=%b expected map=%h cnt=%0d pul=%b",
               name, bus.map, bus.active_cnt, pulses(), m, c, p);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.hit_pos = HIT_NONE;
    bus.rnd     = 9'd0;

    // Start game, first spawn at hole 3
    vecs.push_back(mk(0, 1, 15, 9'd3,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd3,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd3,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd3,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd3,  9'h008, 1, 4'b1000));
    // Candidate 3 busy -> hole 4
    vecs.push_back(mk(0, 1, 15, 9'd12, 9'h008, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd12, 9'h008, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd12, 9'h008, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd12, 9'h018, 2, 4'b1000));
    // Whiff on empty hole 5
    vecs.push_back(mk(0, 1, 5,  9'd12, 9'h018, 2, 4'b0010));
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h018, 2, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h018, 2, 4'b0000));
    // Wrap at MAX_ACTIVE: skipped
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h018, 2, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h018, 2, 4'b0000));
    // Hit on hole 3 in its expiry cycle counts as hit only
    vecs.push_back(mk(0, 1, 3,  9'd0,  9'h010, 1, 4'b0100));
    vecs.push_back(mk(0, 1, 15, 9'h1FF, 9'h010, 1, 4'b0000));
    // rnd[3:0]=15 folds to hole 6
    vecs.push_back(mk(0, 1, 15, 9'h1FF, 9'h050, 2, 4'b1000));
    vecs.push_back(mk(0, 1, 15, 9'd8,  9'h050, 2, 4'b0000));
    // Hole 4 expires unhit
    vecs.push_back(mk(0, 1, 15, 9'd8,  9'h040, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 15, 9'd8,  9'h040, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd8,  9'h140, 2, 4'b1000));
    vecs.push_back(mk(0, 1, 8,  9'd7,  9'h040, 1, 4'b0100));
    // hit_pos 9 is no hit
    vecs.push_back(mk(0, 1, 9,  9'd7,  9'h040, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd7,  9'h040, 1, 4'b0000));
    // Spawn hole 7 and hit hole 6 on the same edge
    vecs.push_back(mk(0, 1, 6,  9'd7,  9'h080, 1, 4'b1100));
    vecs.push_back(mk(0, 1, 15, 9'd7,  9'h080, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd7,  9'h080, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd7,  9'h080, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd7,  9'h180, 2, 4'b1000));
    // en low mid-RUN with a pending hit: silent clear
    vecs.push_back(mk(0, 0, 7,  9'd7,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 0, 15, 9'd0,  9'h000, 0, 4'b0000));
    // Restart: spawn counter begins again from 0
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd0,  9'h001, 1, 4'b1000));
    // rst mid-RUN overrides en and a pending hit
    vecs.push_back(mk(1, 1, 0,  9'd0,  9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd13, 9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd13, 9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd13, 9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd13, 9'h000, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 15, 9'd13, 9'h010, 1, 4'b1000));

    // Reset state
    step();
    step();
    check("reset", 9'h000, 4'd0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].rst;
      bus.en      = vecs[i].en;
      bus.hit_pos = vecs[i].hit;
      bus.rnd     = vecs[i].rnd;
      step();
      check($sformatf("row%0d", i), vecs[i].map, vecs[i].cnt, vecs[i].pul);
    end

    // Hole 4 placed by the last row expires 10 edges later; in between,
    // a spawn lands in hole 5 (candidate 4 busy) and the next wrap is capped.
    begin
      int  edges;
      bit  seen;
      rst         = 1'b0;
      bus.en      = 1'b1;
      bus.hit_pos = HIT_NONE;
      bus.rnd     = 9'd4;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 20) begin
        step();
        edges++;
        if (edges == 4) check("spawn_h5", 9'h030, 4'd2, 4'b1000);
        if (edges == 8) check("capped", 9'h030, 4'd2, 4'b0000);
        if (bus.miss_pulse === 1'b1) seen = 1'b1;
      end
      checks++;
      if (edges != 10) begin
        failures++;
        $display("FAIL miss_latency got %0d edges expected 10", edges);
      end
      check("after_miss", 9'h020, 4'd1, 4'b0001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
